// File: rtl/braille_cell_driver.sv
// braille_cell_driver
//    Drives one 8-dot braille cell built from solenoid pins. Each new pattern
//    is energised in two groups, LEFT (dots 1,2,3,7) and then RIGHT
//    (dots 4,5,6,8). The two groups are never on in the same cycle. A settle
//    dwell follows, and then done pulses. A pattern that equals the one
//    already shown skips all pin activity and pulses done on the next cycle.
//
// Ports
//    clk         single clock, rising edge
//    reset       synchronous active-low reset
//    cell_in     requested pattern, bit n = dot n+1
//    cell_valid  cell_in holds a pattern to display
//    cell_ready  block can accept a pattern this cycle (state == IDLE)
//    pin_drive   registered solenoid drive, bit n = dot n+1, 1 = energised
//    busy        high whenever the block is not idle
//    done        registered one-cycle pulse when a cell update completes
//
// States
//    state     | meaning
//    ----------+-------------------------------------------------
//    S_IDLE    | waiting for a pattern; cell_ready = 1
//    S_DRIVE_L | energising latch & LEFT for PULSE_CYCLES cycles
//    S_DRIVE_R | energising latch & RIGHT for PULSE_CYCLES cycles
//    S_HOLD    | pins off, settle for HOLD_CYCLES cycles

module braille_cell_driver #(
   parameter int unsigned PULSE_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] cell_in,
   input  logic       cell_valid,
   output logic       cell_ready,
   output logic [7:0] pin_drive,
   output logic       busy,
   output logic       done
);

   localparam logic [7:0]  LEFT_MASK  = 8'h47;
   localparam logic [7:0]  RIGHT_MASK = 8'hB8;
   // The counter is loaded with N-1 on state entry and the state exits at
   // zero, so a state lasts exactly N cycles.
   localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES - 1);
   localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DRIVE_L = 2'd1,
      S_DRIVE_R = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  latch_q, latch_d;
   logic [7:0]  displayed_q, displayed_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  pin_drive_q, pin_drive_d;
   logic        done_q, done_d;

   assign cell_ready = (state_q == S_IDLE);
   assign busy       = ~cell_ready;
   assign pin_drive  = pin_drive_q;
   assign done       = done_q;

   always_comb begin
      state_d     = state_q;
      latch_d     = latch_q;
      displayed_d = displayed_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cell_valid) begin
               latch_d = cell_in;
               if (cell_in == displayed_q) begin
                  done_d = 1'b1;
               end else if ((cell_in & LEFT_MASK) != 8'h00) begin
                  state_d = S_DRIVE_L;
                  cnt_d   = PULSE_LOAD;
               end else if ((cell_in & RIGHT_MASK) != 8'h00) begin
                  state_d = S_DRIVE_R;
                  cnt_d   = PULSE_LOAD;
               end else begin
                  state_d = S_HOLD;
                  cnt_d   = HOLD_LOAD;
               end
            end
         end

         S_DRIVE_L: begin
            if (cnt_q == 16'd0) begin
               if ((latch_q & RIGHT_MASK) != 8'h00) begin
                  state_d = S_DRIVE_R;
                  cnt_d   = PULSE_LOAD;
               end else begin
                  state_d = S_HOLD;
                  cnt_d   = HOLD_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         S_DRIVE_R: begin
            if (cnt_q == 16'd0) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LOAD;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         S_HOLD: begin
            if (cnt_q == 16'd0) begin
               state_d     = S_IDLE;
               displayed_d = latch_q;
               done_d      = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
         end
      endcase

      // The pin register follows the state being entered. This lets the
      // drive pattern appear in the first cycle of each phase while the
      // output stays registered.
      unique case (state_d)
         S_DRIVE_L: pin_drive_d = latch_d & LEFT_MASK;
         S_DRIVE_R: pin_drive_d = latch_d & RIGHT_MASK;
         default:   pin_drive_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         latch_q     <= 8'h00;
         displayed_q <= 8'h00;
         cnt_q       <= 16'd0;
         pin_drive_q <= 8'h00;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         latch_q     <= latch_d;
         displayed_q <= displayed_d;
         cnt_q       <= cnt_d;
         pin_drive_q <= pin_drive_d;
         done_q      <= done_d;
      end
   end

endmodule
